pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Sequences the IF/ID and ID/EX pipeline registers of the 5-stage core.
- Detects load-use hazards between the ID and EX stages and stalls the front end while injecting bubbles into ID/EX.
- Flushes wrong-path instructions on taken branches and jumps resolved in EX.
- Holds the front end for memory-indirect jumps (jumpMem) until the target returns from the MEM stage.
- Maintains saturating performance counters.

Parameters:
- REG_AW, 6, register-address width; matches the rd field width.
- LOAD_USE_STALL, 1, bubble cycles per load-use hazard; must be >= 1.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_rs_addr  in  REG_AW  rs address of the instruction in ID.
- id_rt_addr  in  REG_AW  rt address of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rd_addr  in  REG_AW  rd address held in ID/EX.
- ex_mem_read  in  1  ID/EX memRead.
- ex_reg_wrt  in  1  ID/EX regWrt.
- ex_branch_taken  in  1  branchN/branchZ condition met, or jump, resolved in EX.
- ex_jump_mem  in  1  ID/EX jumpMem.
- mem_target_valid  in  1  jumpMem target is available from data memory this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads all-zero control signals (bubble).
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.
- flush_events  out  CNT_W  count of taken-branch and jumpMem flushes.

Behaviour:
- FSM states: RUN, STALL_LU, JMEM_WAIT. Reset state is RUN.
- Control outputs are combinational from the current state and inputs, so they act in the same cycle. Counters are registered.
- While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1. State goes to RUN, the stall count goes to 0, and both counters go to 0. Reset asserted mid-stall or mid-wait aborts it with no residual effect.
- Default outputs in RUN with no event: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0.
- Load-use hazard lu: ex_mem_read & ex_reg_wrt & ((id_uses_rs & id_rs_addr==ex_rd_addr) | (id_uses_rt & id_rt_addr==ex_rd_addr)).
  - All register addresses compare, including 0; there is no hardwired-zero exception.
- Priority in RUN: ex_jump_mem > ex_branch_taken > lu.
- RUN with ex_jump_mem:
  - Outputs: pc_write=0, ifid_flush=1, idex_flush=1.
  - flush_events +1; next state JMEM_WAIT.
- RUN with ex_branch_taken:
  - Outputs: pc_write=1 (redirect), ifid_flush=1, idex_flush=1, ifid_write=1.
  - flush_events +1; stay in RUN. Any lu in the same cycle is ignored because the ID instruction is wrong-path.
- RUN with lu:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
  - If LOAD_USE_STALL>1: load the stall count with LOAD_USE_STALL-1 and go to STALL_LU. Otherwise stay in RUN.
- STALL_LU:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1.
  - Decrement the stall count each cycle. When the count reaches 1, the next state is RUN.
  - ex_* inputs are ignored, since EX holds a bubble.
- JMEM_WAIT:
  - Outputs: ifid_flush=1, idex_flush=1.
  - pc_write=mem_target_valid. On mem_target_valid, the next state is RUN.
  - No timeout. ex_* inputs are ignored.
- Total stall for one hazard is exactly LOAD_USE_STALL cycles.
- stall_cycles: +1 on every non-reset cycle with pc_write=0; saturates at 2^CNT_W-1.
- flush_events: saturates the same way.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum {RUN, STALL_LU, JMEM_WAIT}
  - the REG_AW default
  - the NOP encoding reused by IF/ID.
- One natural sub-module: sat_counter (CNT_W, inc) → count. It is instantiated twice.

Test Plan:
- Reset scenario:
  - Stimulus: hold rst=1 for 2 cycles, then release.
  - During reset: pc_write=0, idex_flush=1, both counters 0.
  - After release: pc_write=1, ifid_write=1, all flush outputs 0.
- Load-use, LOAD_USE_STALL=1:
  - Stimulus: ex_mem_read=1, ex_reg_wrt=1, ex_rd_addr=5, id_rs_addr=5, id_uses_rs=1.
  - Response: for exactly one cycle, pc_write=0, ifid_write=0, idex_flush=1. stall_cycles=1.
  - Repeat with id_uses_rs=0: no stall.
- Load-use, LOAD_USE_STALL=3:
  - Stimulus: match on rt=9, then drive random ex_* inputs during the stall.
  - Response: exactly 3 consecutive stall cycles, then RUN. stall_cycles=3.
- Taken branch with simultaneous lu:
  - Response: one cycle with ifid_flush=1, idex_flush=1, pc_write=1. No stall. flush_events=1.
- jumpMem:
  - Stimulus: ex_jump_mem=1; mem_target_valid asserted 4 cycles later.
  - Response: pc_write=0 for 4 cycles, flushes asserted throughout, pc_write=1 on the valid cycle, then RUN.
  - Stimulus: assert rst during JMEM_WAIT.
  - Response: returns to RUN.
- Saturation, CNT_W=4:
  - Stimulus: 20 stall cycles.
  - Response: stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline hazard controller.
//   state_e     hazard-controller FSM states
//   REG_AW_DEF  default register-address width (matches the rd field)
//   NOP_INSTR   instruction word IF/ID holds after a flush
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STALL_LU  = 2'd1,
    JMEM_WAIT = 2'd2
  } state_e;

  localparam int REG_AW_DEF = 6;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that steps up by one and saturates at all-ones.
//   clk    core clock, rising edge
//   rst    synchronous reset, active-high; clears the count
//   inc    add one this cycle (ignored once saturated)
//   count  current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: IF/ID and ID/EX sequencing for the 5-stage core.
// Stalls on load-use hazards, flushes on taken branches/jumps resolved in
// EX, and holds the front end while a jumpMem target comes back from MEM.
//   clk, rst                   core clock; synchronous active-high reset
//   id_*                       source operands of the instruction in ID
//   ex_*                       control of the instruction in ID/EX
//   mem_target_valid           jumpMem target available this cycle
//   pc_write, ifid_write       load enables (combinational)
//   ifid_flush, idex_flush     NOP / bubble injection (combinational)
//   stall_cycles, flush_events saturating performance counters
//
// state     | meaning
// RUN       | normal flow; hazards and redirects detected here
// STALL_LU  | remaining load-use bubble cycles after the first
// JMEM_WAIT | front end held until the jumpMem target arrives
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW         = REG_AW_DEF,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_mem_read,
  input  logic              ex_reg_wrt,
  input  logic              ex_branch_taken,
  input  logic              ex_jump_mem,
  input  logic              mem_target_valid,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  // Stall counter only has to hold LOAD_USE_STALL-1; keep at least one bit.
  localparam int SW = (LOAD_USE_STALL > 1) ? $clog2(LOAD_USE_STALL) : 1;
  localparam logic [SW-1:0] STALL_INIT = SW'(LOAD_USE_STALL - 1);

  state_e        state_q, state_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          lu;
  logic          flush_inc;
  logic          stall_inc;

  // Address 0 is compared like any other register.
  assign lu = ex_mem_read & ex_reg_wrt &
              ((id_uses_rs & (id_rs_addr == ex_rd_addr)) |
               (id_uses_rt & (id_rt_addr == ex_rd_addr)));

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    flush_inc   = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      state_d     = RUN;
      stall_cnt_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_jump_mem) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            state_d    = JMEM_WAIT;
          end else if (ex_branch_taken) begin
            // Redirect wins over lu: the ID instruction is wrong-path.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
          end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              stall_cnt_d = STALL_INIT;
              state_d     = STALL_LU;
            end
          end
        end
        STALL_LU: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_flush  = 1'b1;
          stall_cnt_d = stall_cnt_q - SW'(1);
          if (stall_cnt_q == SW'(1)) begin
            state_d = RUN;
          end
        end
        JMEM_WAIT: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          pc_write   = mem_target_valid;
          if (mem_target_valid) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_inc = ~rst & ~pc_write;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share the input bus:
// u1 (LOAD_USE_STALL=1, CNT_W=16) and u3 (LOAD_USE_STALL=3, CNT_W=4); each
// has its own reset so only one is active at a time.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic [5:0] id_rs_addr, id_rt_addr, ex_rd_addr;
  logic       id_uses_rs, id_uses_rt;
  logic       ex_mem_read, ex_reg_wrt, ex_branch_taken, ex_jump_mem;
  logic       mem_target_valid;

  logic        pw1, iw1, if1, ix1;
  logic [15:0] sc1, fe1;
  logic        pw3, iw3, if3, ix3;
  logic [3:0]  sc3, fe3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(6), .LOAD_USE_STALL(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst1),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_reg_wrt(ex_reg_wrt), .ex_branch_taken(ex_branch_taken),
    .ex_jump_mem(ex_jump_mem), .mem_target_valid(mem_target_valid),
    .pc_write(pw1), .ifid_write(iw1), .ifid_flush(if1), .idex_flush(ix1),
    .stall_cycles(sc1), .flush_events(fe1)
  );

  pipe_hazard_ctrl #(.REG_AW(6), .LOAD_USE_STALL(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst3),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_reg_wrt(ex_reg_wrt), .ex_branch_taken(ex_branch_taken),
    .ex_jump_mem(ex_jump_mem), .mem_target_valid(mem_target_valid),
    .pc_write(pw3), .ifid_write(iw3), .ifid_flush(if3), .idex_flush(ix3),
    .stall_cycles(sc3), .flush_events(fe3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs_addr = '0; id_rt_addr = '0; ex_rd_addr = 6'd63;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_reg_wrt = 1'b0;
    ex_branch_taken = 1'b0; ex_jump_mem = 1'b0; mem_target_valid = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    idle_inputs();

    // Reset held for two cycles
    step(); #1;
    chk("rst_pc_write", 32'(pw1), 32'd0);
    chk("rst_ifid_write", 32'(iw1), 32'd0);
    chk("rst_ifid_flush", 32'(if1), 32'd1);
    chk("rst_idex_flush", 32'(ix1), 32'd1);
    step(); #1;
    chk("rst_stall_cnt", 32'(sc1), 32'd0);
    chk("rst_flush_cnt", 32'(fe1), 32'd0);
    rst1 = 1'b0; #1;
    chk("run_pc_write", 32'(pw1), 32'd1);
    chk("run_ifid_write", 32'(iw1), 32'd1);
    chk("run_ifid_flush", 32'(if1), 32'd0);
    chk("run_idex_flush", 32'(ix1), 32'd0);

    // Load-use on rs, LOAD_USE_STALL=1
    step();
    ex_mem_read = 1'b1; ex_reg_wrt = 1'b1; ex_rd_addr = 6'd5;
    id_rs_addr = 6'd5; id_uses_rs = 1'b1; #1;
    chk("lu1_pc_write", 32'(pw1), 32'd0);
    chk("lu1_ifid_write", 32'(iw1), 32'd0);
    chk("lu1_idex_flush", 32'(ix1), 32'd1);
    chk("lu1_ifid_flush", 32'(if1), 32'd0);
    step();
    id_uses_rs = 1'b0; #1;
    chk("lu1_no_use_pc_write", 32'(pw1), 32'd1);
    chk("lu1_no_use_idex_flush", 32'(ix1), 32'd0);
    chk("lu1_stall_cnt", 32'(sc1), 32'd1);

    // Address 0 still matches (rt path)
    step();
    ex_rd_addr = 6'd0; id_rt_addr = 6'd0; id_uses_rt = 1'b1; #1;
    chk("lu_r0_pc_write", 32'(pw1), 32'd0);
    step();
    ex_reg_wrt = 1'b0; #1;
    chk("lu_no_regwrt_pc_write", 32'(pw1), 32'd1);
    chk("lu_r0_stall_cnt", 32'(sc1), 32'd2);

    // Taken branch with simultaneous load-use
    step();
    ex_reg_wrt = 1'b1; ex_branch_taken = 1'b1; #1;
    chk("br_pc_write", 32'(pw1), 32'd1);
    chk("br_ifid_write", 32'(iw1), 32'd1);
    chk("br_ifid_flush", 32'(if1), 32'd1);
    chk("br_idex_flush", 32'(ix1), 32'd1);
    step();
    idle_inputs(); #1;
    chk("br_after_ifid_flush", 32'(if1), 32'd0);
    chk("br_flush_cnt", 32'(fe1), 32'd1);
    chk("br_stall_cnt", 32'(sc1), 32'd2);

    // jumpMem: target valid 4 cycles after the jump is seen
    step();
    ex_jump_mem = 1'b1; #1;
    chk("jm0_pc_write", 32'(pw1), 32'd0);
    chk("jm0_ifid_flush", 32'(if1), 32'd1);
    chk("jm0_idex_flush", 32'(ix1), 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      ex_jump_mem = 1'b0; ex_branch_taken = 1'b1; #1;
      chk($sformatf("jm%0d_pc_write", i), 32'(pw1), 32'd0);
      chk($sformatf("jm%0d_ifid_flush", i), 32'(if1), 32'd1);
      chk($sformatf("jm%0d_idex_flush", i), 32'(ix1), 32'd1);
    end
    step();
    ex_branch_taken = 1'b0; mem_target_valid = 1'b1; #1;
    chk("jm_valid_pc_write", 32'(pw1), 32'd1);
    chk("jm_valid_ifid_flush", 32'(if1), 32'd1);
    chk("jm_valid_idex_flush", 32'(ix1), 32'd1);
    step();
    mem_target_valid = 1'b0; #1;
    chk("jm_done_pc_write", 32'(pw1), 32'd1);
    chk("jm_done_ifid_flush", 32'(if1), 32'd0);
    chk("jm_flush_cnt", 32'(fe1), 32'd2);
    chk("jm_stall_cnt", 32'(sc1), 32'd6);

    // Reset in the middle of JMEM_WAIT
    step();
    ex_jump_mem = 1'b1; #1;
    step();
    ex_jump_mem = 1'b0; #1;
    chk("jmr_wait_pc_write", 32'(pw1), 32'd0);
    step();
    rst1 = 1'b1; #1;
    chk("jmr_rst_pc_write", 32'(pw1), 32'd0);
    step();
    rst1 = 1'b0; #1;
    chk("jmr_run_pc_write", 32'(pw1), 32'd1);
    chk("jmr_run_ifid_flush", 32'(if1), 32'd0);
    chk("jmr_run_idex_flush", 32'(ix1), 32'd0);
    chk("jmr_stall_cnt", 32'(sc1), 32'd0);
    chk("jmr_flush_cnt", 32'(fe1), 32'd0);

    // LOAD_USE_STALL=3 instance: rt match, random ex_* during the stall
    rst1 = 1'b1;
    step();
    rst3 = 1'b0; #1;
    chk("lu3_run_pc_write", 32'(pw3), 32'd1);
    step();
    ex_mem_read = 1'b1; ex_reg_wrt = 1'b1; ex_rd_addr = 6'd9;
    id_rt_addr = 6'd9; id_uses_rt = 1'b1; id_rs_addr = 6'd3; #1;
    chk("lu3_c0_pc_write", 32'(pw3), 32'd0);
    chk("lu3_c0_ifid_write", 32'(iw3), 32'd0);
    chk("lu3_c0_idex_flush", 32'(ix3), 32'd1);
    for (int i = 1; i < 3; i++) begin
      step();
      ex_rd_addr = 6'($urandom); ex_mem_read = 1'($urandom);
      ex_reg_wrt = 1'($urandom); ex_jump_mem = 1'b1; ex_branch_taken = 1'b1; #1;
      chk($sformatf("lu3_c%0d_pc_write", i), 32'(pw3), 32'd0);
      chk($sformatf("lu3_c%0d_ifid_write", i), 32'(iw3), 32'd0);
      chk($sformatf("lu3_c%0d_ifid_flush", i), 32'(if3), 32'd0);
      chk($sformatf("lu3_c%0d_idex_flush", i), 32'(ix3), 32'd1);
    end
    step();
    idle_inputs(); #1;
    chk("lu3_done_pc_write", 32'(pw3), 32'd1);
    chk("lu3_done_idex_flush", 32'(ix3), 32'd0);
    chk("lu3_stall_cnt", 32'(sc3), 32'd3);
    chk("lu3_flush_cnt", 32'(fe3), 32'd0);

    // Saturation: 20 more stall cycles on the 4-bit counter
    ex_mem_read = 1'b1; ex_reg_wrt = 1'b1; ex_rd_addr = 6'd9;
    id_rt_addr = 6'd9; id_uses_rt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      chk($sformatf("sat_c%0d_pc_write", i), 32'(pw3), 32'd0);
    end
    step();
    chk("sat_mid_stall_cnt", 32'(sc3), 32'd15);
    idle_inputs();
    repeat (3) step();
    #1;
    chk("sat_pc_write", 32'(pw3), 32'd1);
    chk("sat_stall_cnt", 32'(sc3), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
